// File: rtl/rv64_alu.sv
// RV64I integer ALU: combinational result/illegal plus a registered result-and-flags stage.
// Optional M-extension multiply subset (MUL/MULH/MULHSU/MULHU) is built when ALU_MUL_EN is defined.
module rv64_alu (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [63:0]        rs1,
    input  logic [63:0]        rs2,
    input  logic [2:0]         func3,
    input  logic [6:0]         func7,
    output logic signed [63:0] rd,
    output logic               illegal,
    output logic [63:0]        rd_q,
    output logic               zero_q,
    output logic               neg_q,
    output logic               carry_q,
    output logic               ovf_q,
    output logic               illegal_q
);

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    logic        sub_s;
    logic [63:0] addend_s;
    logic [64:0] sum_s;
    logic        add_ovf_s;
    logic        sub_ovf_s;
    logic [5:0]  shamt_s;
    logic [63:0] sll_s;
    logic [63:0] srl_s;
    logic [63:0] sra_s;
    logic        slt_s;
    logic        sltu_s;

    logic [63:0] res_s;
    logic        ill_s;
    logic        carry_s;
    logic        ovf_s;

    logic [63:0] rd_d;
    logic        zero_d;
    logic        neg_d;

    // SUB shares the adder as rs1 + ~rs2 + 1 so sum_s[64] is the no-borrow carry.
    assign sub_s     = (func7 == F7_ALT);
    assign addend_s  = sub_s ? ~rs2 : rs2;
    assign sum_s     = {1'b0, rs1} + {1'b0, addend_s} + {64'd0, sub_s};
    assign add_ovf_s = (rs1[63] == rs2[63]) && (sum_s[63] != rs1[63]);
    assign sub_ovf_s = (rs1[63] != rs2[63]) && (sum_s[63] != rs1[63]);

    assign shamt_s = rs2[5:0];
    assign sll_s   = rs1 << shamt_s;
    assign srl_s   = rs1 >> shamt_s;
    assign sra_s   = $signed(rs1) >>> shamt_s;
    assign slt_s   = ($signed(rs1) < $signed(rs2));
    assign sltu_s  = (rs1 < rs2);

`ifdef ALU_MUL_EN
    logic         mul_a_sgn_s;
    logic         mul_b_sgn_s;
    logic [127:0] mul_a_s;
    logic [127:0] mul_b_s;
    logic [127:0] mul_p_s;

    // Sign-extending both operands to 128 bits makes the low 128 product bits exact for every signedness mix.
    assign mul_a_sgn_s = (func3 == 3'b001) || (func3 == 3'b010);
    assign mul_b_sgn_s = (func3 == 3'b001);
    assign mul_a_s     = {{64{mul_a_sgn_s & rs1[63]}}, rs1};
    assign mul_b_s     = {{64{mul_b_sgn_s & rs2[63]}}, rs2};
    assign mul_p_s     = mul_a_s * mul_b_s;
`endif

    // Operation decode and result/flag selection.
    always_comb begin
        res_s   = 64'd0;
        ill_s   = 1'b0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (func7)
            F7_BASE: begin
                case (func3)
                    3'b000: begin
                        res_s   = sum_s[63:0];
                        carry_s = sum_s[64];
                        ovf_s   = add_ovf_s;
                    end
                    3'b001:  res_s = sll_s;
                    3'b010:  res_s = {63'd0, slt_s};
                    3'b011:  res_s = {63'd0, sltu_s};
                    3'b100:  res_s = rs1 ^ rs2;
                    3'b101:  res_s = srl_s;
                    3'b110:  res_s = rs1 | rs2;
                    3'b111:  res_s = rs1 & rs2;
                    default: res_s = 64'd0;
                endcase
            end
            F7_ALT: begin
                case (func3)
                    3'b000: begin
                        res_s   = sum_s[63:0];
                        carry_s = sum_s[64];
                        ovf_s   = sub_ovf_s;
                    end
                    3'b101:  res_s = sra_s;
                    default: ill_s = 1'b1;
                endcase
            end
            F7_MUL: begin
`ifdef ALU_MUL_EN
                case (func3)
                    3'b000:  res_s = mul_p_s[63:0];
                    3'b001:  res_s = mul_p_s[127:64];
                    3'b010:  res_s = mul_p_s[127:64];
                    3'b011:  res_s = mul_p_s[127:64];
                    default: ill_s = 1'b1;
                endcase
`else
                ill_s = 1'b1;
`endif
            end
            default: ill_s = 1'b1;
        endcase
    end

    assign rd      = $signed(res_s);
    assign illegal = ill_s;
    assign rd_d    = res_s;
    assign zero_d  = (res_s == 64'd0);
    assign neg_d   = res_s[63];

    // Registered result and status flags for the execute/writeback pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q      <= 64'd0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (en) begin
            rd_q      <= rd_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            carry_q   <= carry_s;
            ovf_q     <= ovf_s;
            illegal_q <= ill_s;
        end else begin
            rd_q      <= rd_q;
            zero_q    <= zero_q;
            neg_q     <= neg_q;
            carry_q   <= carry_q;
            ovf_q     <= ovf_q;
            illegal_q <= illegal_q;
        end
    end

endmodule

// File: tb/tb_rv64_alu.sv
// Scoreboard bench for rv64_alu: directed vectors push expectations; a monitor pops on each enabled capture.
module tb_rv64_alu;

    logic               clk;
    logic               reset;
    logic               en;
    logic [63:0]        rs1;
    logic [63:0]        rs2;
    logic [2:0]         func3;
    logic [6:0]         func7;
    logic signed [63:0] rd;
    logic               illegal;
    logic [63:0]        rd_q;
    logic               zero_q;
    logic               neg_q;
    logic               carry_q;
    logic               ovf_q;
    logic               illegal_q;

    typedef struct packed {
        logic [63:0] rd;
        logic        ill;
        logic        carry;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [6:0] F7B = 7'b0000000;
    localparam logic [6:0] F7A = 7'b0100000;
    localparam logic [6:0] F7M = 7'b0000001;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    rv64_alu dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .rs1       (rs1),
        .rs2       (rs2),
        .func3     (func3),
        .func7     (func7),
        .rd        (rd),
        .illegal   (illegal),
        .rd_q      (rd_q),
        .zero_q    (zero_q),
        .neg_q     (neg_q),
        .carry_q   (carry_q),
        .ovf_q     (ovf_q),
        .illegal_q (illegal_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [63:0] e_rd, input logic e_ill,
                         input logic e_c, input logic e_o);
        exp_t e;
        @(negedge clk);
        rs1   = a;
        rs2   = b;
        func3 = f3;
        func7 = f7;
        en    = 1'b1;
        e.rd    = e_rd;
        e.ill   = e_ill;
        e.carry = e_c;
        e.ovf   = e_o;
        sb_q.push_back(e);
    endtask

    // Monitor: every edge that captures pops one expectation and checks both comb and registered views.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (reset && en) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL capture_without_expectation at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("rd_comb", rd, e.rd);
                    check("illegal_comb", {63'd0, illegal}, {63'd0, e.ill});
                    #1;
                    check("rd_q", rd_q, e.rd);
                    check("zero_q", {63'd0, zero_q}, {63'd0, (e.rd == 64'd0)});
                    check("neg_q", {63'd0, neg_q}, {63'd0, e.rd[63]});
                    check("carry_q", {63'd0, carry_q}, {63'd0, e.carry});
                    check("ovf_q", {63'd0, ovf_q}, {63'd0, e.ovf});
                    check("illegal_q", {63'd0, illegal_q}, {63'd0, e.ill});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        rs1   = 64'd0;
        rs2   = 64'd0;
        func3 = 3'b000;
        func7 = F7B;
        #3;
        check("reset_rd_q", rd_q, 64'd0);
        check("reset_flags", {58'd0, zero_q, neg_q, carry_q, ovf_q, illegal_q, 1'b0}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(64'h1C, 64'd4, 3'b000, F7B, 64'h20, 1'b0, 1'b0, 1'b0);
        issue(64'd5, 64'd7, 3'b000, F7A, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, F7B, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'h44, 3'b101, F7A, 64'hF800_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'h44, 3'b101, F7B, 64'h0800_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        issue(ONES, 64'd1, 3'b010, F7B, 64'd1, 1'b0, 1'b0, 1'b0);
        issue(ONES, 64'd1, 3'b011, F7B, 64'd0, 1'b0, 1'b0, 1'b0);
        issue(64'd1, ONES, 3'b001, F7B, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        issue(64'hF0F0, 64'hFF00, 3'b100, F7B, 64'h0FF0, 1'b0, 1'b0, 1'b0);
        issue(64'hF0F0, 64'hFF00, 3'b110, F7B, 64'hFFF0, 1'b0, 1'b0, 1'b0);
        issue(64'hF0F0, 64'hFF00, 3'b111, F7B, 64'hF000, 1'b0, 1'b0, 1'b0);
        issue(64'd3, 64'd3, 3'b000, F7A, 64'd0, 1'b0, 1'b1, 1'b0);
        issue(ONES, 64'd1, 3'b000, F7B, 64'd0, 1'b0, 1'b1, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'd1, 3'b000, F7A, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
        issue(64'h1234, 64'h5678, 3'b000, 7'b0000010, 64'd0, 1'b1, 1'b0, 1'b0);
        issue(64'h1234, 64'h5678, 3'b001, F7A, 64'd0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_MUL_EN
        issue(ONES, 64'd2, 3'b011, F7M, 64'd1, 1'b0, 1'b0, 1'b0);
        issue(ONES, 64'd2, 3'b001, F7M, ONES, 1'b0, 1'b0, 1'b0);
        issue(64'd6, 64'd7, 3'b000, F7M, 64'd42, 1'b0, 1'b0, 1'b0);
        issue(64'd6, 64'd7, 3'b100, F7M, 64'd0, 1'b1, 1'b0, 1'b0);
`else
        issue(ONES, 64'd2, 3'b011, F7M, 64'd0, 1'b1, 1'b0, 1'b0);
        issue(64'd6, 64'd7, 3'b000, F7M, 64'd0, 1'b1, 1'b0, 1'b0);
`endif
        issue(64'h1C, 64'd4, 3'b000, F7B, 64'h20, 1'b0, 1'b0, 1'b0);

        // Hold: en low with changed inputs must not disturb the registered stage.
        @(negedge clk);
        en  = 1'b0;
        rs1 = 64'h55;
        @(posedge clk);
        #1;
        check("hold_rd_q", rd_q, 64'h20);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b0;
        #1;
        check("async_rd_q", rd_q, 64'd0);
        check("async_flags", {58'd0, zero_q, neg_q, carry_q, ovf_q, illegal_q, 1'b0}, 64'd0);
        rs1   = 64'h100;
        rs2   = 64'h23;
        func3 = 3'b000;
        func7 = F7B;
        #1;
        check("rd_during_reset", rd, 64'h123);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("reset_wins_rd_q", rd_q, 64'd0);
        check("reset_wins_zero_q", {63'd0, zero_q}, 64'd0);
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_hold", rd_q, 64'd0);

        issue(64'h1C, 64'd4, 3'b000, F7B, 64'h20, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("sb_final_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
